upuart_txfifo: RTL and testbench
================================

UPUART_TXFIFO -- requirements
Module: upuart_txfifo

Interface
REQ-001 Parameter: ADDR_W, default 4, log2 of FIFO depth (DEPTH = 2^ADDR_W = 16 entries).
REQ-002 Parameter: DATA_W, default 8, entry width in bits.
REQ-003 Port: clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 Port: nrst  input  1  reset; synchronous, active-low.
REQ-005 Port: flush  input  1  discard all entries (one-cycle pulse from control register).
REQ-006 Port: wr_data  input  DATA_W  byte written by register interface.
REQ-007 Port: wr_en  input  1  push request, one byte per cycle.
REQ-008 Port: data_out  output  DATA_W  head entry, first-word-fall-through; drives the transmitter's data_in.
REQ-009 Port: data_valid  output  1  FIFO not empty; drives the transmitter's data_valid.
REQ-010 Port: data_rd  input  1  pop request from the transmitter (single-cycle pulse).
REQ-011 Port: full  output  1  count equals DEPTH.
REQ-012 Port: count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
REQ-013 Port: thr  input  ADDR_W+1  low-water threshold.
REQ-014 Port: low_irq  output  1  registered; high when count <= thr.
REQ-015 Port: clr_err  input  1  clear sticky error flags.
REQ-016 Port: ovf  output  1  sticky; push dropped because FIFO was full.
REQ-017 Port: udf  output  1  sticky; pop requested while empty.

Function
REQ-018 Storage SHALL be a DEPTH x DATA_W register array with ADDR_W-bit write and read pointers that wrap modulo DEPTH.
REQ-019 data_out SHALL combinationally equal the entry at the read pointer; data_valid SHALL equal (count != 0).
REQ-020 Push (wr_en, not full): write wr_data at write pointer, increment write pointer; the entry becomes visible on data_out/data_valid the cycle after the push edge (1-cycle latency).
REQ-021 Pop (data_rd, not empty): increment read pointer; the next entry or data_valid=0 appears the cycle after the pop edge.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH: both SHALL be performed; count unchanged.
REQ-023 Simultaneous push and pop when full: both SHALL be performed, count stays DEPTH, ovf not set.
REQ-024 Simultaneous push and pop when empty: push performed, pop ignored, udf set, count becomes 1.
REQ-025 Push when full without pop: data dropped, pointers unchanged, ovf set.
REQ-026 Pop when empty without push: ignored, udf set.
REQ-027 flush SHALL clear both pointers and count on that edge, ignoring wr_en/data_rd that cycle; ovf/udf SHALL NOT be set by that cycle.
REQ-028 clr_err SHALL clear ovf and udf; if a new error occurs in the same cycle, set wins.
REQ-029 count SHALL be a registered counter updated +1/-1/0 per REQ-020..027, never exceeding DEPTH.
REQ-030 low_irq SHALL be registered from the next-cycle count value, so it is coherent with count in the same cycle.

Reset
REQ-031 On clk edge with nrst=0: pointers=0, count=0, data_valid=0, full=0, ovf=0, udf=0, low_irq=1 (count 0 <= any thr); array contents need not be reset.
REQ-032 Reset SHALL take priority over flush, push and pop; any in-flight entries are discarded.

Structure
REQ-033 Pointer/count arithmetic and flag logic SHALL live in this module; the storage array MAY be a sub-module upuart_fifo_mem (write port, asynchronous read port) so the RX FIFO can reuse it.
REQ-034 Default ADDR_W/DATA_W SHALL be shared constants in the UART auxiliary include alongside the existing vote helper.

Verification
REQ-035 Reset, push 0x55 -> next cycle data_valid=1, data_out=0x55, count=1; pulse data_rd -> next cycle data_valid=0, count=0.
REQ-036 Push 16 bytes 0x00..0x0F -> full=1, count=16; 17th push 0xAA -> ovf=1, pop all returns 0x00..0x0F in order.
REQ-037 Fill to 16 then push+pop same cycle -> count stays 16, ovf=0; data order preserved across pointer wrap.
REQ-038 Empty, pulse data_rd -> udf=1; clr_err together with another empty pop -> udf stays 1; clr_err alone -> udf=0.
REQ-039 thr=2, push 3 -> low_irq=0; pop 1 -> low_irq=1 the cycle count=2.
REQ-040 Count=5, flush with simultaneous wr_en -> next cycle count=0, data_valid=0; nrst low mid-operation -> all outputs per REQ-031.

Source files
------------

// File: rtl/upuart_txfifo_pkg.sv
// upuart_txfifo_pkg: shared UART auxiliary constants and helpers.
// FIFO geometry defaults live here so the TX and RX FIFOs stay in step.
package upuart_txfifo_pkg;

    localparam int UART_FIFO_ADDR_W = 4;
    localparam int UART_FIFO_DATA_W = 8;

    function automatic logic vote3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/upuart_fifo_mem.sv
// upuart_fifo_mem: register-array storage with one write port and one asynchronous read port.
module upuart_fifo_mem import upuart_txfifo_pkg::*; #(
    parameter int ADDR_W = UART_FIFO_ADDR_W,
    parameter int DATA_W = UART_FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/upuart_txfifo.sv
// upuart_txfifo: first-word-fall-through transmit FIFO with occupancy count,
// low-water interrupt and sticky overflow/underflow flags.
module upuart_txfifo import upuart_txfifo_pkg::*; #(
    parameter int ADDR_W = UART_FIFO_ADDR_W,
    parameter int DATA_W = UART_FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_rd,
    output logic              full,
    output logic [ADDR_W:0]   count,
    input  logic [ADDR_W:0]   thr,
    output logic              low_irq,
    input  logic              clr_err,
    output logic              ovf,
    output logic              udf
);

    logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d, udf_q, udf_d, low_q, low_d;
    logic              empty, push, pop;

    // count never exceeds DEPTH, so its MSB alone marks the full state
    assign full  = cnt_q[ADDR_W];
    assign empty = cnt_q == '0;

    always_comb begin
        push  = !flush && wr_en && (!full || data_rd);
        pop   = !flush && data_rd && !empty;
        wp_d  = flush ? '0 : wp_q + ADDR_W'(push);
        rp_d  = flush ? '0 : rp_q + ADDR_W'(pop);
        cnt_d = flush ? '0 : cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        ovf_d = (!flush && wr_en && full && !data_rd) || (ovf_q && !clr_err);
        udf_d = (!flush && data_rd && empty) || (udf_q && !clr_err);
        low_d = cnt_d <= thr;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            low_q <= 1'b1;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            low_q <= low_d;
        end
    end

    upuart_fifo_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wp_q),
        .wdata (wr_data),
        .raddr (rp_q),
        .rdata (data_out)
    );

    assign data_valid = !empty;
    assign count      = cnt_q;
    assign low_irq    = low_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

endmodule

// File: tb/tb_upuart_txfifo.sv
// tb_upuart_txfifo: directed bench with a queue scoreboard of pushed bytes.
module tb_upuart_txfifo;

    logic       clk = 1'b0;
    logic       nrst, flush, wr_en, data_rd, clr_err;
    logic [7:0] wr_data, data_out;
    logic       data_valid, full, low_irq, ovf, udf;
    logic [4:0] count, thr;

    logic [7:0] sb[$];
    logic       e_ovf, e_udf, e_low;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    upuart_txfifo dut (
        .clk(clk), .nrst(nrst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .data_out(data_out), .data_valid(data_valid), .data_rd(data_rd), .full(full),
        .count(count), .thr(thr), .low_irq(low_irq), .clr_err(clr_err), .ovf(ovf), .udf(udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(sb.size()));
        chk("data_valid", 32'(data_valid), 32'(sb.size() != 0));
        chk("full", 32'(full), 32'(sb.size() == 16));
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("udf", 32'(udf), 32'(e_udf));
        chk("low_irq", 32'(low_irq), 32'(e_low));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic f = 1'b0, input logic c = 1'b0);
        logic was_full, was_empty;
        wr_en = w; wr_data = d; data_rd = r; flush = f; clr_err = c;
        #1;
        was_full  = sb.size() == 16;
        was_empty = sb.size() == 0;
        if (f) begin
            sb.delete();
            if (c) begin e_ovf = 1'b0; e_udf = 1'b0; end
        end else begin
            if (c) begin e_ovf = 1'b0; e_udf = 1'b0; end
            if (r && !was_empty) begin
                chk("head", 32'(data_out), 32'(sb[0]));
                void'(sb.pop_front());
            end
            if (w && (!was_full || r)) sb.push_back(d);
            if (w && was_full && !r) e_ovf = 1'b1;
            if (r && was_empty) e_udf = 1'b1;
        end
        @(posedge clk); #1;
        wr_en = 1'b0; data_rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
        e_low = 5'(sb.size()) <= thr;
        check_state();
    endtask

    task automatic reset_cycle(input logic w);
        nrst = 1'b0; wr_en = w; wr_data = 8'hEE; data_rd = w; flush = w;
        @(posedge clk); #1;
        nrst = 1'b1; wr_en = 1'b0; data_rd = 1'b0; flush = 1'b0;
        sb.delete(); e_ovf = 1'b0; e_udf = 1'b0; e_low = 1'b1;
        check_state();
    endtask

    initial begin
        nrst = 1'b0; flush = 1'b0; wr_en = 1'b0; data_rd = 1'b0; clr_err = 1'b0;
        wr_data = 8'h00; thr = 5'd0;
        e_ovf = 1'b0; e_udf = 1'b0; e_low = 1'b1;
        @(posedge clk); #1;
        reset_cycle(1'b0);

        // single push then pop
        step(1'b1, 8'h55, 1'b0);
        chk("head55", 32'(data_out), 32'h55);
        step(1'b0, 8'h00, 1'b1);

        // fill, overflow, drain in order
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // push+pop while full, across pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, 8'h90 + 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h40 + 8'(i), 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

        // underflow stickiness and clear priority
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // low-water threshold
        thr = 5'd2;
        for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        chk("low_at3", 32'(low_irq), 32'h0);
        step(1'b0, 8'h00, 1'b1);
        chk("low_at2", 32'(low_irq), 32'h1);
        for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1);
        thr = 5'd16;

        // flush with simultaneous push, then reset mid-operation
        for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
        step(1'b1, 8'hDD, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
        step(1'b1, 8'hAB, 1'b0);
        thr = 5'd0;
        reset_cycle(1'b1);
        step(1'b1, 8'h11, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
